// File: rtl/mixsx_lanes_if.sv
// mixsx_lanes_if: request/result bundle for mixsx_lanes.
//   master: start, mode, c, x, d, cout_ready   -> block
//   slave : busy, cout, cout_valid, idx_err    -> requester / downstream
interface mixsx_lanes_if #(
  parameter int unsigned CWORDS64 = 2,
  parameter int unsigned XWORDS32 = 2
);
  localparam int unsigned IDX_W = $clog2(XWORDS32);
  localparam int unsigned DW    = CWORDS64 * IDX_W;

  logic                     start;
  logic [1:0]               mode;
  logic [CWORDS64*64-1:0]   c;
  logic [XWORDS32*32-1:0]   x;
  logic [DW-1:0]            d;
  logic                     busy;
  logic [CWORDS64*64-1:0]   cout;
  logic                     cout_valid;
  logic                     cout_ready;
  logic                     idx_err;

  modport master (
    output start, mode, c, x, d, cout_ready,
    input  busy, cout, cout_valid, idx_err
  );

  modport slave (
    input  start, mode, c, x, d, cout_ready,
    output busy, cout, cout_valid, idx_err
  );
endinterface

// File: rtl/mixsx_lanes.sv
// mixsx_lanes: XORs table word x[d[i]] into the low, high or both halves of
// each 64-bit word of c, LANES words per cycle, with start/busy request and
// valid/ready result handshake. idx_err flags any d[i] >= XWORDS32.
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      mixsx_lanes_if.slave (start/mode/c/x/d in, busy/cout/
//            cout_valid/idx_err out, cout_ready in)
module mixsx_lanes #(
  parameter int unsigned CWORDS64 = 2,
  parameter int unsigned XWORDS32 = 2,
  parameter int unsigned LANES    = 1
) (
  input  logic          clk,
  input  logic          reset_n,
  mixsx_lanes_if.slave  bus
);
  localparam int unsigned IDX_W = $clog2(XWORDS32);
  localparam int unsigned DW    = CWORDS64 * IDX_W;
  localparam int unsigned NGRP  = (CWORDS64 + LANES - 1) / LANES;
  localparam int unsigned CNT_W = $clog2(NGRP) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         g_q, g_d;
  logic [CWORDS64*64-1:0]   c_q, c_d;
  logic [XWORDS32*32-1:0]   x_q, x_d;
  logic [DW-1:0]            d_q, d_d;
  logic [1:0]               mode_q, mode_d;
  logic                     err_q, err_d;

  logic                     accept;
  logic                     last_grp;
  logic [CWORDS64*64-1:0]   c_mix;
  logic                     err_mix;
  int unsigned              wi;
  int unsigned              idx;
  logic [31:0]              xw;

  assign accept   = (state_q == IDLE) && bus.start;
  assign last_grp = (g_q == CNT_W'(NGRP - 1));

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (last_grp) state_d = DONE;
      DONE:    if (bus.cout_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    bus.busy       = (state_q != IDLE);
    bus.cout_valid = (state_q == DONE);
    bus.cout       = (state_q == DONE) ? c_q : '0;
    bus.idx_err    = (state_q == DONE) ? err_q : 1'b0;
  end

  // Datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      g_q    <= '0;
      c_q    <= '0;
      x_q    <= '0;
      d_q    <= '0;
      mode_q <= '0;
      err_q  <= 1'b0;
    end else begin
      g_q    <= g_d;
      c_q    <= c_d;
      x_q    <= x_d;
      d_q    <= d_d;
      mode_q <= mode_d;
      err_q  <= err_d;
    end
  end

  always_comb begin
    g_d    = g_q;
    c_d    = c_q;
    x_d    = x_q;
    d_d    = d_q;
    mode_d = mode_q;
    err_d  = err_q;
    if (accept) begin
      g_d    = '0;
      c_d    = bus.c;
      x_d    = bus.x;
      d_d    = bus.d;
      mode_d = bus.mode;
      err_d  = 1'b0;
    end else if (state_q == RUN) begin
      g_d   = g_q + CNT_W'(1);
      c_d   = c_mix;
      err_d = err_q | err_mix;
    end
  end

  // Per-group mixing; lanes past the last word of a ragged group do nothing.
  always_comb begin
    c_mix   = c_q;
    err_mix = 1'b0;
    wi      = 0;
    idx     = 0;
    xw      = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      wi = 32'(g_q) * LANES + k;
      if (wi < CWORDS64 && mode_q != 2'd3) begin
        idx = 32'(d_q[wi*IDX_W +: IDX_W]);
        if (idx < XWORDS32) begin
          xw = x_q[idx*32 +: 32];
        end else begin
          xw      = '0;
          err_mix = 1'b1;
        end
        if (mode_q != 2'd1) c_mix[wi*64 +: 32]      = c_mix[wi*64 +: 32] ^ xw;
        if (mode_q != 2'd0) c_mix[wi*64 + 32 +: 32] = c_mix[wi*64 + 32 +: 32] ^ xw;
      end
    end
  end
endmodule
